// File: rtl/adc128s022_ctrl.sv
// ADC128S022 SPI master: round-robin channel scan with a one-entry valid/ready output buffer.
// The ADC returns the conversion addressed in the previous frame, so each result carries that tag.
module adc128s022_ctrl #(
    parameter int unsigned HALF_DIV = 8
) (
    input  logic        clk_i,
    input  logic        n_reset_i,
    input  logic        enable_i,
    input  logic [7:0]  chan_mask_i,
    output logic        adc_cs_n_o,
    output logic        adc_sclk_o,
    output logic        adc_saddr_o,
    input  logic        adc_sdat_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [2:0]  out_chan_o,
    output logic [11:0] out_data_o,
    output logic        overflow_o,
    input  logic        overflow_clr_i
);

    localparam int unsigned DivW = $clog2(HALF_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(HALF_DIV - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      bit_q, bit_d;
    logic            cs_n_q, cs_n_d, sclk_q, sclk_d, saddr_q, saddr_d;
    logic [10:0]     shreg_q, shreg_d;
    logic [2:0]      last_addr_q, last_addr_d;
    logic [2:0]      tx_addr_q, tx_addr_d;
    logic [2:0]      rx_chan_q, rx_chan_d;
    logic            valid_q, valid_d, ovf_q, ovf_d;
    logic [2:0]      ochan_q, ochan_d;
    logic [11:0]     odata_q, odata_d;
    logic            start_frame, done, ovf_set;
    logic [15:0]     word;

    // First set mask bit strictly after last, wrapping; an empty mask selects channel 0.
    function automatic logic [2:0] next_addr(input logic [7:0] mask, input logic [2:0] last);
        logic [2:0] idx;
        next_addr = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            idx = last + 3'(i);
            if (mask[idx]) next_addr = idx;
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        saddr_d     = saddr_q;
        shreg_d     = shreg_q;
        last_addr_d = last_addr_q;
        tx_addr_d   = tx_addr_q;
        rx_chan_d   = rx_chan_q;
        valid_d     = valid_q;
        ochan_d     = ochan_q;
        odata_d     = odata_q;
        start_frame = 1'b0;
        done        = 1'b0;
        ovf_set     = 1'b0;
        word        = {2'b00, tx_addr_q, 11'b0};

        unique case (state_q)
            StIdle: begin
                if (enable_i) start_frame = 1'b1;
            end
            StSetup: begin
                if (div_q == DivLast) begin
                    state_d = StShift;
                    div_d   = '0;
                    bit_d   = 4'd0;
                    sclk_d  = 1'b0;
                    saddr_d = word[15];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q != DivLast) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Last low-phase cycle: capture DOUT as SCLK is driven high.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[9:0], adc_sdat_i};
                        done    = (bit_q == 4'd15);
                    end else if (bit_q == 4'd15) begin
                        state_d = StHold;
                        cs_n_d  = 1'b1;
                        saddr_d = 1'b0;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 4'd1;
                        saddr_d = word[4'd14 - bit_q];
                    end
                end
            end
            StHold: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (enable_i) start_frame = 1'b1;
                    else          state_d     = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_frame) begin
            state_d     = StSetup;
            cs_n_d      = 1'b0;
            div_d       = '0;
            rx_chan_d   = tx_addr_q;
            tx_addr_d   = next_addr(chan_mask_i, last_addr_q);
            last_addr_d = tx_addr_d;
        end

        if (valid_q && out_ready_i) valid_d = 1'b0;
        if (done) begin
            if (valid_q && !out_ready_i) begin
                ovf_set = 1'b1;
            end else begin
                valid_d = 1'b1;
                ochan_d = rx_chan_q;
                odata_d = {shreg_q, adc_sdat_i};
            end
        end
        ovf_d = ovf_set ? 1'b1 : (overflow_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= 4'd0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            saddr_q     <= 1'b0;
            shreg_q     <= '0;
            last_addr_q <= 3'd7;
            tx_addr_q   <= 3'd0;
            rx_chan_q   <= 3'd0;
            valid_q     <= 1'b0;
            ochan_q     <= 3'd0;
            odata_q     <= 12'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            saddr_q     <= saddr_d;
            shreg_q     <= shreg_d;
            last_addr_q <= last_addr_d;
            tx_addr_q   <= tx_addr_d;
            rx_chan_q   <= rx_chan_d;
            valid_q     <= valid_d;
            ochan_q     <= ochan_d;
            odata_q     <= odata_d;
            ovf_q       <= ovf_d;
        end
    end

    assign adc_cs_n_o  = cs_n_q;
    assign adc_sclk_o  = sclk_q;
    assign adc_saddr_o = saddr_q;
    assign out_valid_o = valid_q;
    assign out_chan_o  = ochan_q;
    assign out_data_o  = odata_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_adc128s022_ctrl.sv
// Bench for adc128s022_ctrl: behavioural ADC, independent scan model and a sample scoreboard.
module tb_adc128s022_ctrl;

    localparam int unsigned HalfDiv = 8;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  chan_mask = 8'h00;
    logic        adc_cs_n, adc_sclk, adc_saddr;
    logic        adc_sdat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_chan;
    logic [11:0] out_data;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    adc128s022_ctrl #(.HALF_DIV(HalfDiv)) dut (
        .clk_i          (clk),
        .n_reset_i      (n_reset),
        .enable_i       (enable),
        .chan_mask_i    (chan_mask),
        .adc_cs_n_o     (adc_cs_n),
        .adc_sclk_o     (adc_sclk),
        .adc_saddr_o    (adc_saddr),
        .adc_sdat_i     (adc_sdat),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_chan_o     (out_chan),
        .out_data_o     (out_data),
        .overflow_o     (overflow),
        .overflow_clr_i (overflow_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [11:0] vals [8];
    logic [14:0] pend_q [$];   // {chan, data} expected per frame, in completion order
    logic [2:0]  addr_q [$];   // expected DIN address per frame
    logic        mdl_full = 1'b0, exp_ovf = 1'b0, xfer_pending = 1'b0, mon_en = 1'b0;
    logic        chk_len = 1'b0;
    logic [2:0]  buf_chan = 3'd0;
    logic [11:0] buf_data = 12'd0;
    logic [2:0]  last_a = 3'd7, prev_a = 3'd0, exp_a, adc_next = 3'd0;
    logic [15:0] conv_word = 16'd0, din_cap = 16'd0;
    int          fall_cnt = 0, rise_cnt = 0, frames_done = 0, sclk_edges = 0;
    int          cyc = 0, cs_fall_cyc = 0, last_rise_cyc = 0;

    function automatic logic [2:0] mdl_next(input logic [7:0] mask, input logic [2:0] last);
        logic [2:0] a;
        a = last;
        for (int i = 0; i < 8; i++) begin
            a = a + 3'd1;
            if (mask[a]) return a;
        end
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (xfer_pending) begin
            mdl_full     = 1'b0;
            xfer_pending = 1'b0;
        end
        if (overflow_clr) exp_ovf = 1'b0;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("out_valid", out_valid, mdl_full);
            check_eq("overflow", overflow, exp_ovf);
            if (adc_cs_n) check_eq("saddr_idle", adc_saddr, 1'b0);
            if (mdl_full && out_ready) begin
                check_eq("out_chan", out_chan, buf_chan);
                check_eq("out_data", out_data, buf_data);
                xfer_pending = 1'b1;
            end
        end
    end

    always @(adc_sclk) sclk_edges++;

    always @(negedge adc_cs_n) begin
        if (n_reset) begin
            exp_a = mdl_next(chan_mask, last_a);
            pend_q.push_back({prev_a, vals[prev_a]});
            addr_q.push_back(exp_a);
            last_a    = exp_a;
            prev_a    = exp_a;
            conv_word = {4'b0, vals[adc_next]};
            fall_cnt  = 0;
            rise_cnt  = 0;
            din_cap   = 16'd0;
            if (chk_len) check_eq("frame_len", cyc - cs_fall_cyc, 34 * HalfDiv);
            cs_fall_cyc = cyc;
        end
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs_n && n_reset) begin
            if (fall_cnt == 0) check_eq("sclk_lead", cyc - cs_fall_cyc, HalfDiv);
            if (fall_cnt < 16) adc_sdat = conv_word[15 - fall_cnt];
            fall_cnt++;
        end
    end

    always @(posedge adc_sclk) begin
        if (!adc_cs_n && n_reset) begin
            din_cap = {din_cap[14:0], adc_saddr};
            rise_cnt++;
            last_rise_cyc = cyc;
            if (rise_cnt == 16) begin
                if (pend_q.size() == 0) begin
                    check_eq("pend_avail", pend_q.size(), 1);
                end else if (mdl_full) begin
                    void'(pend_q.pop_front());
                    exp_ovf = 1'b1;
                end else begin
                    {buf_chan, buf_data} = pend_q.pop_front();
                    mdl_full = 1'b1;
                end
            end
        end
    end

    always @(posedge adc_cs_n) begin
        if (n_reset) begin
            frames_done++;
            check_eq("sclk_pulses", rise_cnt, 16);
            check_eq("cs_tail", cyc - last_rise_cyc, HalfDiv);
            check_eq("din_zero", din_cap & 16'hC7FF, 16'h0000);
            if (addr_q.size() == 0) check_eq("addr_avail", addr_q.size(), 1);
            else                    check_eq("din_addr", din_cap[13:11], addr_q.pop_front());
            adc_next = din_cap[13:11];
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        pend_q.delete();
        addr_q.delete();
        mdl_full = 1'b0; exp_ovf = 1'b0; xfer_pending = 1'b0; mon_en = 1'b1;
        last_a = 3'd7; prev_a = 3'd0; adc_next = 3'd0;
        #1;
        check_eq("rst_cs_n", adc_cs_n, 1'b1);
        check_eq("rst_sclk", adc_sclk, 1'b1);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_saddr", adc_saddr, 1'b0);
        check_eq("rst_chan", out_chan, 3'd0);
        check_eq("rst_data", out_data, 12'd0);
        check_eq("rst_ovf", overflow, 1'b0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
    endtask

    task automatic wait_frames(input int n);
        int tgt = frames_done + n;
        int budget = n * 400;
        while (frames_done < tgt && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_eq("frame_wait", frames_done >= tgt, 1'b1);
    endtask

    task automatic wait_fall16();
        int budget = 800;
        while (fall_cnt == 16 && budget > 0) begin @(posedge clk); #1; budget--; end
        while (fall_cnt != 16 && budget > 0) begin @(posedge clk); #1; budget--; end
        check_eq("fall16_wait", fall_cnt, 16);
    endtask

    task automatic wait_cs_low();
        int budget = 400;
        while (adc_cs_n && budget > 0) begin @(posedge clk); #1; budget--; end
        check_eq("cs_low_wait", adc_cs_n, 1'b0);
    endtask

    task automatic stop_and_drain();
        enable    = 1'b0;
        out_ready = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        check_eq("drain_pend", pend_q.size(), 0);
        check_eq("drain_full", mdl_full, 1'b0);
        check_eq("idle_cs_n", adc_cs_n, 1'b1);
        check_eq("idle_sclk", adc_sclk, 1'b1);
    endtask

    initial begin
        int edges;
        vals[0] = 12'h3C1; vals[1] = 12'h1E7; vals[2] = 12'h2B4; vals[3] = 12'hA5C;
        vals[4] = 12'h4D2; vals[5] = 12'h5A5; vals[6] = 12'h69F; vals[7] = 12'hF07;

        // Single channel: frame timing, pipeline tag, DIN address.
        do_reset();
        chan_mask = 8'h08;
        repeat (5) @(posedge clk);
        #1 check_eq("sclk_idle_high", adc_sclk, 1'b1);
        enable = 1'b1;
        wait_frames(1);
        chk_len = 1'b1;
        wait_frames(2);
        chk_len = 1'b0;
        stop_and_drain();

        // Round robin over channels 0, 5, 7.
        do_reset();
        chan_mask = 8'b1010_0001;
        enable = 1'b1;
        wait_frames(5);
        stop_and_drain();

        // Empty mask.
        do_reset();
        chan_mask = 8'h00;
        enable = 1'b1;
        wait_frames(3);
        stop_and_drain();

        // Backpressure and overflow.
        do_reset();
        chan_mask = 8'h02;
        out_ready = 1'b0;
        enable = 1'b1;
        wait_frames(2);
        check_eq("bp_ovf", overflow, 1'b1);
        check_eq("bp_held_chan", out_chan, 3'd0);
        check_eq("bp_held_data", out_data, vals[0]);
        wait_fall16();
        repeat (HalfDiv - 1) @(posedge clk);
        #1 overflow_clr = 1'b1;
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        check_eq("bp_clr_vs_set", overflow, 1'b1);
        repeat (4) @(posedge clk);
        #1 overflow_clr = 1'b1;
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        check_eq("bp_lone_clr", overflow, 1'b0);
        wait_fall16();
        repeat (HalfDiv - 1) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq("bp_accept_load_ovf", overflow, 1'b0);
        check_eq("bp_accept_load_valid", out_valid, 1'b1);
        stop_and_drain();

        // Enable dropped mid-SHIFT: frame completes, then idle.
        do_reset();
        chan_mask = 8'h04;
        enable = 1'b1;
        wait_cs_low();
        repeat (100) @(posedge clk);
        #1 enable = 1'b0;
        wait_frames(1);
        edges = sclk_edges;
        repeat (60) @(posedge clk);
        #1;
        check_eq("drop_no_sclk", sclk_edges, edges);
        check_eq("drop_cs_n", adc_cs_n, 1'b1);
        check_eq("drop_delivered", pend_q.size() + int'(mdl_full), 0);
        stop_and_drain();

        // Asynchronous reset in the middle of a frame.
        do_reset();
        chan_mask = 8'h01;
        enable = 1'b1;
        wait_frames(1);
        wait_cs_low();
        repeat (100) @(posedge clk);
        do_reset();
        wait_frames(2);
        stop_and_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
